// File: rtl/function_sequencer.sv
// rtl/function_sequencer.sv - streams consecutive rows of a constant table as a flow-controlled burst
// Define FUNCTION_SEQUENCER_ROT_EN to add a rot input that rotates each row left as it is loaded.
module function_sequencer #(
   parameter int                   K_N      = 256,
   parameter int                   DEPTH    = 4,
   parameter int                   AW       = 2,
   parameter int                   CW       = 8,
   parameter logic [K_N*DEPTH-1:0] ROW_INIT = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [AW-1:0]            start_adrs,
   input  logic [CW-1:0]            count,
   input  logic                     abort,
`ifdef FUNCTION_SEQUENCER_ROT_EN
   input  logic [$clog2(K_N)-1:0]   rot,
`endif
   output logic [K_N-1:0]           f,
   output logic                     f_valid,
   input  logic                     f_ready,
   output logic [AW-1:0]            adrs_out,
   output logic                     last,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic [K_N-1:0]  f_q, f_d;
   logic            f_valid_q, f_valid_d;
   logic [AW-1:0]   adrs_q, adrs_d;
   logic [CW-1:0]   rem_q, rem_d;
   logic            done_q, done_d;

   logic [AW-1:0]   adrs_nxt;
   logic [AW-1:0]   sel_adrs;
   logic [K_N-1:0]  row_src;
   logic [K_N-1:0]  row_fmt;

   // Addresses past the last row (possible when DEPTH is not a power of two) read as zero.
   function automatic logic [K_N-1:0] row_at(input logic [AW-1:0] a);
      logic [K_N-1:0] r;
      r = '0;
      if (int'(a) < DEPTH) r = ROW_INIT[int'(a)*K_N +: K_N];
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      f_d       = f_q;
      f_valid_d = f_valid_q;
      adrs_d    = adrs_q;
      rem_d     = rem_q;
      done_d    = 1'b0;

      adrs_nxt = (adrs_q == AW'(DEPTH - 1)) ? '0 : adrs_q + 1'b1;
      sel_adrs = (state_q == IDLE) ? start_adrs : adrs_nxt;
      row_src  = row_at(sel_adrs);
`ifdef FUNCTION_SEQUENCER_ROT_EN
      row_fmt  = (row_src << rot) | (row_src >> (K_N - int'(rot)));
`else
      row_fmt  = row_src;
`endif

      if (abort) begin
         state_d   = IDLE;
         f_valid_d = 1'b0;
         rem_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (count != '0) begin
                     f_d       = row_fmt;
                     adrs_d    = start_adrs;
                     f_valid_d = 1'b1;
                     rem_d     = count;
                     state_d   = RUN;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            RUN: begin
               if (f_valid_q && f_ready) begin
                  if (rem_q > CW'(1)) begin
                     f_d    = row_fmt;
                     adrs_d = adrs_nxt;
                     rem_d  = rem_q - CW'(1);
                  end else begin
                     f_valid_d = 1'b0;
                     rem_d     = '0;
                     done_d    = 1'b1;
                     state_d   = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         f_q       <= '0;
         f_valid_q <= 1'b0;
         adrs_q    <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         f_q       <= f_d;
         f_valid_q <= f_valid_d;
         adrs_q    <= adrs_d;
         rem_q     <= rem_d;
         done_q    <= done_d;
      end
   end

   assign f        = f_q;
   assign f_valid  = f_valid_q;
   assign adrs_out = adrs_q;
   assign last     = f_valid_q && (rem_q == CW'(1));
   assign busy     = (state_q == RUN);
   assign done     = done_q;

endmodule
